// File: rtl/port_queue_scheduler.sv
// -----------------------------------------------------------------------------
// port_queue_scheduler
//   Packet scheduler for one egress port. It keeps a packet count for each
//   priority queue of the port. It picks the next priority to read, using
//   either strict priority or weighted round robin. It issues one grant per
//   packet and does not grant again until the read path reports that packet's
//   EOP. It also returns per-priority full and almost_full flags to the write
//   side.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   asynchronous, active-low reset
//   sp0_wrr1     in   0 = strict priority, 1 = weighted round robin
//   wrr_weight   in   WRR weight of prio p at [p*WGT_W +: WGT_W] (0 acts as 1)
//   ready        in   downstream can accept a packet of prio p
//   enq_vld      in   one packet for this port was committed to SRAM
//   enq_prio     in   priority of the enqueued packet
//   pkt_done     in   read path sent the EOP of the granted packet
//   gnt_vld      out  1-cycle pulse: read the head packet of gnt_prio
//   gnt_prio     out  granted priority, held until the next grant
//   busy         out  a grant is outstanding
//   full         out  cnt[p] == DEPTH
//   almost_full  out  cnt[p] >= DEPTH - AF_MARGIN
//   enq_drop     out  1-cycle pulse: enqueue rejected because the queue is full
// -----------------------------------------------------------------------------
module port_queue_scheduler #(
    parameter int NUM_PRIO  = 8,
    parameter int PRIO_W    = 3,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 7,
    parameter int AF_MARGIN = 4,
    parameter int WGT_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sp0_wrr1,
    input  logic [NUM_PRIO*WGT_W-1:0] wrr_weight,
    input  logic [NUM_PRIO-1:0]       ready,
    input  logic                      enq_vld,
    input  logic [PRIO_W-1:0]         enq_prio,
    input  logic                      pkt_done,
    output logic                      gnt_vld,
    output logic [PRIO_W-1:0]         gnt_prio,
    output logic                      busy,
    output logic [NUM_PRIO-1:0]       full,
    output logic [NUM_PRIO-1:0]       almost_full,
    output logic                      enq_drop
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt [NUM_PRIO];
    logic [PRIO_W-1:0]   r_ptr;
    logic [WGT_W:0]      r_credit;
    logic                r_gnt_vld;
    logic [PRIO_W-1:0]   r_gnt_prio;
    logic                r_enq_drop;

    logic [NUM_PRIO-1:0] w_elig;
    logic [NUM_PRIO-1:0] w_inc;
    logic [NUM_PRIO-1:0] w_dec;
    logic [PRIO_W-1:0]   w_sp_sel;
    logic [PRIO_W-1:0]   w_scan_sel;
    logic [PRIO_W-1:0]   w_wrr_sel;
    logic [PRIO_W-1:0]   w_sel;
    logic [WGT_W-1:0]    w_wgt;
    logic [WGT_W-1:0]    w_eff_wgt;
    logic                w_stay;
    logic [PRIO_W-1:0]   w_ptr_nxt;
    logic [WGT_W:0]      w_credit_nxt;
    logic                w_grant;

    // ---------------------------------------------------------------------
    // Queue status derived from the counters
    // ---------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_PRIO; p++) begin
            w_elig[p]      = (r_cnt[p] != '0) && ready[p];
            full[p]        = (r_cnt[p] == CNT_W'(DEPTH));
            almost_full[p] = (r_cnt[p] >= CNT_W'(DEPTH - AF_MARGIN));
        end
    end

    // ---------------------------------------------------------------------
    // Strict priority: the lowest eligible index wins. The loop runs
    // downwards so that the last match it assigns is the lowest index.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        w_sp_sel = '0;
        for (int p = NUM_PRIO - 1; p >= 0; p--) begin
            if (w_elig[p]) begin
                w_sp_sel = PRIO_W'(p);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Weighted round robin.
    // The current pointer keeps the grant while it is eligible and has
    // credit left in its turn. Otherwise the scan starts at ptr+1. The scan
    // ends back at ptr itself, so a sole eligible queue whose turn is used
    // up still gets served, and it starts a fresh turn.
    // ---------------------------------------------------------------------
    always_comb begin
        w_wgt      = wrr_weight[r_ptr*WGT_W +: WGT_W];
        w_eff_wgt  = (w_wgt == '0) ? WGT_W'(1) : w_wgt;
        w_stay     = w_elig[r_ptr] && (r_credit < {1'b0, w_eff_wgt});

        w_scan_sel = r_ptr;
        for (int k = NUM_PRIO; k >= 1; k--) begin
            if (w_elig[(int'(r_ptr) + k) % NUM_PRIO]) begin
                w_scan_sel = PRIO_W'((int'(r_ptr) + k) % NUM_PRIO);
            end
        end

        if (w_stay) begin
            w_wrr_sel    = r_ptr;
            w_ptr_nxt    = r_ptr;
            w_credit_nxt = r_credit + (WGT_W+1)'(1);
        end else begin
            w_wrr_sel    = w_scan_sel;
            w_ptr_nxt    = w_scan_sel;
            w_credit_nxt = (WGT_W+1)'(1);
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic. The mode and the weights only take effect here
    // in IDLE, so they cannot disturb a grant that is already outstanding.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = sp0_wrr1 ? w_wrr_sel : w_sp_sel;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Counter steering. A grant can only pick a queue with a nonzero count,
    // so the decrement never underflows. An enqueue into a full queue is
    // accepted only when a grant on the same queue frees a slot on the same
    // edge.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_PRIO; p++) begin
            w_dec[p] = w_grant && (w_sel == PRIO_W'(p));
            w_inc[p] = enq_vld && (enq_prio == PRIO_W'(p)) &&
                       ((r_cnt[p] != CNT_W'(DEPTH)) || w_dec[p]);
        end
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_gnt_vld  <= 1'b0;
            r_gnt_prio <= '0;
            r_enq_drop <= 1'b0;
            r_ptr      <= '0;
            r_credit   <= '0;
            // NOTE: the counter array is built from flops, not from a RAM
            // macro, so it can be and must be cleared by reset.
            for (int p = 0; p < NUM_PRIO; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_vld  <= w_grant;
            r_enq_drop <= enq_vld && full[enq_prio] && !w_dec[enq_prio];
            if (w_grant) begin
                r_gnt_prio <= w_sel;
                if (sp0_wrr1) begin
                    r_ptr    <= w_ptr_nxt;
                    r_credit <= w_credit_nxt;
                end
            end
            for (int p = 0; p < NUM_PRIO; p++) begin
                if (w_inc[p] && !w_dec[p]) begin
                    r_cnt[p] <= r_cnt[p] + CNT_W'(1);
                end else if (w_dec[p] && !w_inc[p]) begin
                    r_cnt[p] <= r_cnt[p] - CNT_W'(1);
                end
            end
        end
    end

    assign gnt_vld  = r_gnt_vld;
    assign gnt_prio = r_gnt_prio;
    assign busy     = (r_state == ST_BUSY);
    assign enq_drop = r_enq_drop;

endmodule

// File: tb/tb_port_queue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_port_queue_scheduler
//   Self-checking bench for port_queue_scheduler. Stimulus pushes the expected
//   grant priorities into a scoreboard queue. A monitor pops one entry for each
//   gnt_vld pulse and compares it. A responder returns pkt_done a programmable
//   number of cycles after each grant.
// -----------------------------------------------------------------------------
module tb_port_queue_scheduler;

    localparam int NUM_PRIO = 8;
    localparam int PRIO_W   = 3;
    localparam int WGT_W    = 4;
    localparam int DEPTH    = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      sp0_wrr1;
    logic [NUM_PRIO*WGT_W-1:0] wrr_weight;
    logic [NUM_PRIO-1:0]       ready;
    logic                      enq_vld;
    logic [PRIO_W-1:0]         enq_prio;
    logic                      pkt_done;
    logic                      gnt_vld;
    logic [PRIO_W-1:0]         gnt_prio;
    logic                      busy;
    logic [NUM_PRIO-1:0]       full;
    logic [NUM_PRIO-1:0]       almost_full;
    logic                      enq_drop;

    int                checks      = 0;
    int                failures    = 0;
    int                grants_seen = 0;
    int                grants_exp  = 0;
    int                done_delay  = 1;
    logic [PRIO_W-1:0] exp_q [$];
    logic [PRIO_W-1:0] mon_exp;

    port_queue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sp0_wrr1    (sp0_wrr1),
        .wrr_weight  (wrr_weight),
        .ready       (ready),
        .enq_vld     (enq_vld),
        .enq_prio    (enq_prio),
        .pkt_done    (pkt_done),
        .gnt_vld     (gnt_vld),
        .gnt_prio    (gnt_prio),
        .busy        (busy),
        .full        (full),
        .almost_full (almost_full),
        .enq_drop    (enq_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_gnt(input int p);
        exp_q.push_back(PRIO_W'(p));
        grants_exp++;
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (rst && gnt_vld) begin
            grants_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(gnt_vld), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("gnt_prio", 32'(gnt_prio), 32'(mon_exp));
            end
        end
    end

    // pkt_done responder
    initial begin
        pkt_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && gnt_vld) begin
                repeat (done_delay - 1) @(negedge clk);
                pkt_done = 1'b1;
                @(negedge clk);
                pkt_done = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst      = 1'b0;
        enq_vld  = 1'b0;
        ready    = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic enq(input int p);
        enq_vld  = 1'b1;
        enq_prio = PRIO_W'(p);
        @(negedge clk);
        enq_vld  = 1'b0;
    endtask

    // Wait, within a cycle budget, until every expected grant has appeared
    // and the last packet is done. Then idle for a while, so that any extra
    // grant is caught, and compare the totals.
    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("grant_count", 32'(grants_seen), 32'(grants_exp));
    endtask

    initial begin
        // ---------------- 1: reset ----------------
        rst        = 1'b0;
        sp0_wrr1   = 1'b0;
        wrr_weight = '0;
        ready      = '1;
        enq_vld    = 1'b1;
        enq_prio   = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt_vld", 32'(gnt_vld), 32'd0);
        check("rst_gnt_prio", 32'(gnt_prio), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_enq_drop", 32'(enq_drop), 32'd0);
        enq_vld = 1'b0;
        rst     = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_no_grant", 32'(grants_seen), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        expect_gnt(6);
        enq(6);
        drain(50);

        // ---------------- 2: strict priority ----------------
        do_reset();
        ready = '0;
        enq(5);
        enq(2);
        enq(7);
        expect_gnt(2);
        expect_gnt(5);
        expect_gnt(7);
        ready = '1;
        drain(60);

        // ---------------- 3: WRR, p0 weight 3, p1 weight 1 ----------------
        do_reset();
        sp0_wrr1   = 1'b1;
        wrr_weight = 32'h0000_0013;
        for (int i = 0; i < 6; i++) enq(0);
        for (int i = 0; i < 6; i++) enq(1);
        begin
            int unsigned order [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
            for (int i = 0; i < 12; i++) expect_gnt(int'(order[i]));
        end
        ready = '1;
        drain(120);
        sp0_wrr1   = 1'b0;
        wrr_weight = '0;

        // ---------------- 4: full / almost_full / drop ----------------
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            enq(3);
            if (i == 59) check("af_at_59", 32'(almost_full[3]), 32'd0);
            if (i == 60) begin
                check("af_at_60", 32'(almost_full[3]), 32'd1);
                check("full_at_60", 32'(full[3]), 32'd0);
            end
            if (i == 63) check("full_at_63", 32'(full[3]), 32'd0);
            if (i == 64) begin
                check("full_at_64", 32'(full[3]), 32'd1);
                check("no_drop_at_64", 32'(enq_drop), 32'd0);
            end
        end
        enq(3);
        check("drop_pulse", 32'(enq_drop), 32'd1);
        @(negedge clk);
        check("drop_one_cycle", 32'(enq_drop), 32'd0);
        check("full_after_drop", 32'(full[3]), 32'd1);
        // Enqueue and grant on p3 in the same cycle while full.
        for (int i = 0; i < DEPTH + 1; i++) expect_gnt(3);
        ready    = 8'b0000_1000;
        enq_vld  = 1'b1;
        enq_prio = 3'd3;
        @(negedge clk);
        enq_vld  = 1'b0;
        check("same_cycle_no_drop", 32'(enq_drop), 32'd0);
        check("same_cycle_full", 32'(full[3]), 32'd1);
        drain(400);
        check("full_after_drain", 32'(full[3]), 32'd0);
        check("af_after_drain", 32'(almost_full[3]), 32'd0);

        // ---------------- 5: ready gating ----------------
        do_reset();
        enq(1);
        enq(1);
        repeat (3) @(negedge clk);
        check("gated_no_grant", 32'(gnt_vld), 32'd0);
        check("gated_busy", 32'(busy), 32'd0);
        done_delay = 4;
        expect_gnt(1);
        expect_gnt(1);
        ready = 8'b0000_0010;
        @(negedge clk);
        check("ready_latency_vld", 32'(gnt_vld), 32'd1);
        check("ready_latency_prio", 32'(gnt_prio), 32'd1);
        ready = '0;
        @(negedge clk);
        check("busy_after_ready_drop", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        check("done_completes_grant", 32'(busy), 32'd0);
        check("no_grant_while_unready", 32'(gnt_vld), 32'd0);
        done_delay = 1;
        ready = 8'b0000_0010;
        drain(60);

        // ---------------- 6: reset mid-operation ----------------
        do_reset();
        enq(4);
        enq(4);
        enq(4);
        done_delay = 20;
        expect_gnt(4);
        ready = '1;
        @(negedge clk);
        check("mid_gnt_vld", 32'(gnt_vld), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_gnt_vld", 32'(gnt_vld), 32'd0);
        check("mid_rst_af", 32'(almost_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_no_regrant", 32'(grants_seen), 32'(grants_exp));
        check("mid_rst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
